// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: byte memory read port, decoder word handshake and
// execute-stage redirect inputs.
interface fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic [15:0] word;
  logic [15:0] word_pc;
  logic        word_valid;
  logic        word_ready;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        rjmp_en;
  logic [9:0]  rjmp_offset;

  modport master (
    output mem_addr, mem_read, word, word_pc, word_valid,
    input  mem_data, mem_ready, word_ready, jump_en, jump_addr, rjmp_en, rjmp_offset
  );

  modport slave (
    input  mem_addr, mem_read, word, word_pc, word_valid,
    output mem_data, mem_ready, word_ready, jump_en, jump_addr, rjmp_en, rjmp_offset
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: assembles 16-bit words from two byte reads (low first),
// presents them to the decoder and honours absolute/relative redirects.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH_LO, FETCH_HI, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] word_q, word_nxt;
  logic [15:0] wpc_q, wpc_nxt;
  logic [7:0]  lo, lo_nxt;
  logic        wv, wv_nxt;
  logic        xfer, redirect;
  logic [15:0] target;

  assign bus.mem_read   = reset_n && (state != HOLD);
  assign bus.mem_addr   = (state == FETCH_HI) ? pc + 16'd1 : pc;
  assign bus.word       = word_q;
  assign bus.word_pc    = wpc_q;
  assign bus.word_valid = wv;

  assign xfer     = bus.mem_read && bus.mem_ready;
  assign redirect = bus.jump_en | bus.rjmp_en;
  // Relative target is anchored on the word currently presented, not on pc.
  assign target   = bus.jump_en ? {bus.jump_addr[15:1], 1'b0}
                                : wpc_q + {{5{bus.rjmp_offset[9]}}, bus.rjmp_offset, 1'b0};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    word_nxt  = word_q;
    wpc_nxt   = wpc_q;
    lo_nxt    = lo;
    wv_nxt    = wv;
    if (redirect) begin
      // In-flight bytes are dropped simply by not latching them.
      pc_nxt    = target;
      wv_nxt    = 1'b0;
      state_nxt = FETCH_LO;
    end else begin
      unique case (state)
        FETCH_LO: if (xfer) begin
          lo_nxt    = bus.mem_data;
          state_nxt = FETCH_HI;
        end
        FETCH_HI: if (xfer) begin
          word_nxt  = {bus.mem_data, lo};
          wpc_nxt   = pc;
          wv_nxt    = 1'b1;
          pc_nxt    = pc + 16'd2;
          state_nxt = HOLD;
        end
        HOLD: if (bus.word_ready) begin
          wv_nxt    = 1'b0;
          state_nxt = FETCH_LO;
        end
        default: state_nxt = FETCH_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= FETCH_LO;
      pc     <= {RESET_VECTOR[15:1], 1'b0};
      word_q <= '0;
      wpc_q  <= '0;
      lo     <= '0;
      wv     <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      word_q <= word_nxt;
      wpc_q  <= wpc_nxt;
      lo     <= lo_nxt;
      wv     <= wv_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte-count/word-slot reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_unit;
  localparam logic [15:0] RV = 16'h0100;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [0:65535];

  fetch_unit_if bus();
  fetch_unit #(.RESET_VECTOR(RV)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.mem_data = mem[bus.mem_addr];

  // Reference: next pc, how many bytes of the pending word are collected, and
  // the word slot presented to the decoder.
  bit          m_started = 1'b0;
  logic [15:0] m_pc, m_word, m_wpc;
  logic [7:0]  m_lo;
  int          m_nb;
  bit          m_valid;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_started <= 1'b1;
      m_pc      <= RV & 16'hFFFE;
      m_nb      <= 0;
      m_valid   <= 1'b0;
      m_word    <= '0;
      m_wpc     <= '0;
      m_lo      <= '0;
    end else if (m_started) begin
      if (bus.jump_en || bus.rjmp_en) begin
        if (bus.jump_en) m_pc <= bus.jump_addr & 16'hFFFE;
        else begin
          int d;
          d = $signed(bus.rjmp_offset) * 2;
          m_pc <= 16'(32'(m_wpc) + 32'(d));
        end
        m_valid <= 1'b0;
        m_nb    <= 0;
      end else if (m_valid) begin
        if (bus.word_ready) m_valid <= 1'b0;
      end else if (bus.mem_ready) begin
        if (m_nb == 0) begin
          m_lo <= mem[m_pc];
          m_nb <= 1;
        end else begin
          m_word  <= {mem[16'(m_pc + 16'd1)], m_lo};
          m_wpc   <= m_pc;
          m_pc    <= m_pc + 16'd2;
          m_valid <= 1'b1;
          m_nb    <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("mem_read",   {15'd0, bus.mem_read},   {15'd0, reset_n && !m_valid});
      chk("mem_addr",   bus.mem_addr,   m_valid ? m_pc : 16'(m_pc + 16'(m_nb)));
      chk("word_valid", {15'd0, bus.word_valid}, {15'd0, m_valid});
      chk("word",       bus.word,       m_word);
      chk("word_pc",    bus.word_pc,    m_wpc);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
    mem[16'h0102] = 8'hCD; mem[16'h0103] = 8'hAB;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;
    reset_n = 1'b0;
    bus.mem_ready = 1'b1; bus.word_ready = 1'b1;
    bus.jump_en = 1'b0; bus.jump_addr = '0;
    bus.rjmp_en = 1'b0; bus.rjmp_offset = '0;

    // Reset state and first-word latency
    tick(2);
    chk("rst_valid", {15'd0, bus.word_valid}, 16'd0);
    chk("rst_word", bus.word, 16'h0000);
    chk("rst_mem_read", {15'd0, bus.mem_read}, 16'd0);
    reset_n = 1'b1;
    #1 chk("t1_addr_lo", bus.mem_addr, 16'h0100);
    tick();
    chk("t1_addr_hi", bus.mem_addr, 16'h0101);
    tick();
    chk("t1_valid", {15'd0, bus.word_valid}, 16'd1);
    chk("t1_word", bus.word, 16'h1234);
    chk("t1_word_pc", bus.word_pc, 16'h0100);
    tick();
    chk("t1_next", bus.mem_addr, 16'h0102);

    // Memory stall in the high-byte read
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_addr", bus.mem_addr, 16'h0103);
      chk("t2_stall_valid", {15'd0, bus.word_valid}, 16'd0);
    end
    bus.mem_ready = 1'b1; bus.word_ready = 1'b0;
    tick();
    chk("t2_word", bus.word, 16'hABCD);

    // Decoder back-pressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_word", bus.word, 16'hABCD);
      chk("t3_hold_pc", bus.word_pc, 16'h0102);
      chk("t3_hold_rd", {15'd0, bus.mem_read}, 16'd0);
    end
    bus.word_ready = 1'b1;
    tick();
    chk("t3_release", {15'd0, bus.word_valid}, 16'd0);
    chk("t3_resume", bus.mem_addr, 16'h0104);

    // Redirects
    tick();
    bus.jump_en = 1'b1; bus.jump_addr = 16'h2001;
    tick();
    chk("t4_jump_addr", bus.mem_addr, 16'h2000);
    chk("t4_jump_word", bus.word, 16'hABCD);
    bus.jump_addr = 16'h0200;
    tick();
    bus.jump_en = 1'b0; bus.word_ready = 1'b0;
    tick(2);
    chk("t4_wpc", bus.word_pc, 16'h0200);
    bus.rjmp_en = 1'b1; bus.rjmp_offset = 10'h3FE;
    tick();
    chk("t4_rjmp", bus.mem_addr, 16'h01FC);
    bus.rjmp_offset = 10'd5; bus.jump_en = 1'b1; bus.jump_addr = 16'h3000;
    tick();
    chk("t4_both", bus.mem_addr, 16'h3000);

    // Wrap-around at the top of memory
    bus.rjmp_en = 1'b0; bus.jump_addr = 16'hFFFF; bus.word_ready = 1'b1;
    tick();
    bus.jump_en = 1'b0;
    chk("t5_lo", bus.mem_addr, 16'hFFFE);
    tick();
    chk("t5_hi", bus.mem_addr, 16'hFFFF);
    tick();
    chk("t5_word", bus.word, 16'h5678);
    chk("t5_wpc", bus.word_pc, 16'hFFFE);
    tick();
    chk("t5_wrap", bus.mem_addr, 16'h0000);

    // Reset while holding a word
    bus.word_ready = 1'b0;
    tick(2);
    reset_n = 1'b0;
    tick();
    chk("t6_valid", {15'd0, bus.word_valid}, 16'd0);
    chk("t6_word", bus.word, 16'h0000);
    reset_n = 1'b1;
    #1 chk("t6_restart", bus.mem_addr, 16'h0100);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.mem_ready   = ($urandom_range(3) != 0);
      bus.word_ready  = $urandom_range(1) == 1;
      bus.jump_en     = ($urandom_range(31) == 0);
      bus.rjmp_en     = ($urandom_range(31) == 0);
      bus.jump_addr   = 16'($urandom);
      bus.rjmp_offset = 10'($urandom);
      reset_n         = ($urandom_range(199) != 0);
    end
    reset_n = 1'b1; bus.jump_en = 1'b0; bus.rjmp_en = 1'b0;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
